// File: rtl/board_ram_pkg.sv
// Shared types and default sizes for the board RAM arbiter slice.
package board_ram_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_RD_PEND
  } cpu_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_FETCH
  } owner_t;

endpackage

// File: rtl/board_ram_arbiter_rd_tag_pipe.sv
// Shift register that remembers who issued each RAM read, so the returning
// RAM_Q word can be steered to the CPU or to the tile fetcher.
module rd_tag_pipe
  import board_ram_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  owner_t tag_in,
  output owner_t tag_out
);

  owner_t stage_q [DEPTH];
  owner_t stage_d [DEPTH];

  // Each stage takes the previous one; stage 0 takes the tag of this cycle's access.
  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Reset empties the pipe so no in-flight read ever returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= OWN_NONE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/board_ram_arbiter.sv
// Single-port board RAM arbiter: CPU (Avalon slave) versus VGA tile fetcher.
// The fetcher wins during active video, but only for MAX_STALL grants in a
// row while the CPU waits; reads return through a tag pipe.
module board_ram_arbiter
  import board_ram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = 1,
  parameter int MAX_STALL = 8
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                AVL_CS,
  input  logic                AVL_READ,
  input  logic                AVL_WRITE,
  input  logic [ADDR_W-1:0]   AVL_ADDR,
  input  logic [DATA_W/8-1:0] AVL_BYTE_EN,
  input  logic [DATA_W-1:0]   AVL_WRITEDATA,
  output logic [DATA_W-1:0]   AVL_READDATA,
  output logic                AVL_WAITREQ,
  input  logic                ACTIVE_VIDEO,
  input  logic                FETCH_REQ,
  input  logic [ADDR_W-1:0]   FETCH_ADDR,
  output logic                FETCH_GNT,
  output logic                FETCH_VALID,
  output logic [DATA_W-1:0]   FETCH_DATA,
  output logic [ADDR_W-1:0]   RAM_ADDR,
  output logic [DATA_W-1:0]   RAM_WDATA,
  output logic [DATA_W/8-1:0] RAM_BYTEEN,
  output logic                RAM_WREN,
  input  logic [DATA_W-1:0]   RAM_Q
);

  localparam logic [7:0] STALL_LIMIT = 8'(MAX_STALL);

  cpu_state_t        state_q, state_d;
  logic [7:0]        stall_q, stall_d;
  logic              rd_done_q, rd_done_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              cpu_req, fetch_req;
  logic              cpu_gnt, fetch_gnt;
  logic              cpu_wr_gnt, cpu_rd_gnt;
  owner_t            issue_tag, return_tag;

  // Qualify requests and pick at most one winner for this cycle.
  always_comb begin
    cpu_req   = RESET_N && AVL_CS && (AVL_READ || AVL_WRITE) &&
                (state_q != C_RD_PEND) && !rd_done_q;
    fetch_req = RESET_N && FETCH_REQ;
    cpu_gnt   = 1'b0;
    fetch_gnt = 1'b0;
    if (cpu_req && fetch_req) begin
      if (ACTIVE_VIDEO && (stall_q < STALL_LIMIT)) begin
        fetch_gnt = 1'b1;
      end else begin
        cpu_gnt = 1'b1;
      end
    end else begin
      cpu_gnt   = cpu_req;
      fetch_gnt = fetch_req;
    end
    cpu_wr_gnt = cpu_gnt && AVL_WRITE;
    cpu_rd_gnt = cpu_gnt && !AVL_WRITE;
  end

  // Drive the RAM port from the winner and tag the access for its return path.
  always_comb begin
    RAM_ADDR   = '0;
    RAM_WDATA  = '0;
    RAM_BYTEEN = '0;
    RAM_WREN   = 1'b0;
    issue_tag  = OWN_NONE;
    if (cpu_gnt) begin
      RAM_ADDR = AVL_ADDR;
      if (cpu_wr_gnt) begin
        RAM_WREN   = 1'b1;
        RAM_WDATA  = AVL_WRITEDATA;
        RAM_BYTEEN = AVL_BYTE_EN;
      end else begin
        issue_tag = OWN_CPU;
      end
    end else if (fetch_gnt) begin
      RAM_ADDR  = FETCH_ADDR;
      issue_tag = OWN_FETCH;
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .tag_in  (issue_tag),
    .tag_out (return_tag)
  );

  // Next state for the CPU FSM, starvation counter and read-return register.
  always_comb begin
    state_d    = state_q;
    rd_done_d  = 1'b0;
    readdata_d = readdata_q;
    if (cpu_req && fetch_gnt) begin
      stall_d = stall_q + 8'd1;
    end else begin
      stall_d = 8'd0;
    end
    case (state_q)
      C_IDLE, C_WAIT: begin
        if (cpu_rd_gnt) begin
          state_d = C_RD_PEND;
        end else if (cpu_wr_gnt) begin
          state_d = C_IDLE;
        end else if (cpu_req) begin
          state_d = C_WAIT;
        end else begin
          state_d = C_IDLE;
        end
      end
      C_RD_PEND: begin
        if (return_tag == OWN_CPU) begin
          readdata_d = RAM_Q;
          rd_done_d  = 1'b1;
          state_d    = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  // CPU FSM state and its registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= C_IDLE;
      stall_q    <= 8'd0;
      rd_done_q  <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      rd_done_q  <= rd_done_d;
      readdata_q <= readdata_d;
    end
  end

  assign AVL_WAITREQ  = !(cpu_wr_gnt || rd_done_q);
  assign AVL_READDATA = readdata_q;
  assign FETCH_GNT    = fetch_gnt;
  assign FETCH_VALID  = (return_tag == OWN_FETCH);
  assign FETCH_DATA   = FETCH_VALID ? RAM_Q : '0;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Self-checking bench for board_ram_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a transaction-level reference.
module tb_board_ram_arbiter;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 32;
  localparam int RD_LAT    = 2;
  localparam int MAX_STALL = 8;

  logic        clk, rst_n;
  logic        cs, rd, wr;
  logic [10:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        video, freq;
  logic [10:0] faddr;
  logic [31:0] avl_readdata, fetch_data, ram_wdata, ram_q;
  logic        avl_waitreq, fetch_gnt, fetch_valid, ram_wren;
  logic [10:0] ram_addr;
  logic [3:0]  ram_byteen;

  board_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_STALL(MAX_STALL)
  ) dut (
    .CLK(clk), .RESET_N(rst_n),
    .AVL_CS(cs), .AVL_READ(rd), .AVL_WRITE(wr), .AVL_ADDR(addr),
    .AVL_BYTE_EN(be), .AVL_WRITEDATA(wdata), .AVL_READDATA(avl_readdata),
    .AVL_WAITREQ(avl_waitreq), .ACTIVE_VIDEO(video), .FETCH_REQ(freq),
    .FETCH_ADDR(faddr), .FETCH_GNT(fetch_gnt), .FETCH_VALID(fetch_valid),
    .FETCH_DATA(fetch_data), .RAM_ADDR(ram_addr), .RAM_WDATA(ram_wdata),
    .RAM_BYTEEN(ram_byteen), .RAM_WREN(ram_wren), .RAM_Q(ram_q)
  );

  // Free-running 100 MHz-style clock (period only matters relative to itself).
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM macro with registered, RD_LAT-cycle read data.
  logic [31:0] ram [0:2047];
  logic [31:0] q_pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    q_pipe[0] <= ram[ram_addr];
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end
  assign ram_q = q_pipe[RD_LAT-1];

  // Reference model state
  typedef struct packed { int due; logic [31:0] data; } fetch_t;
  fetch_t      fq[$];
  logic [31:0] ref_mem [0:2047];
  int          total_cnt = 0;
  int          bad_cnt   = 0;
  int          cycle_no  = 0;
  int          wait_grants = 0;
  int          rd_done_cycle = 0;
  logic [31:0] rd_exp = '0;
  bit          cpu_active = 0;
  bit          cpu_busy = 0;
  bit          cpu_done_now = 0;
  bit          fetch_taken = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got !== want) begin
      bad_cnt++;
      $display("[TB] FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cycle_no);
    end
  endtask

  task automatic startCpu(input bit r, input bit w, input logic [10:0] a,
                          input logic [3:0] bytes, input logic [31:0] d);
    cs = 1'b1; rd = r; wr = w; addr = a; be = bytes; wdata = d;
    cpu_active = 1;
  endtask

  // One clock: predict this cycle from the rules, compare, advance the model.
  task automatic stepCycle();
    bit cpu_req_m, f_win, c_win, is_wr, rd_done_now, exp_v;
    @(negedge clk);
    cpu_req_m   = cpu_active && cs && (rd || wr) && !cpu_busy;
    rd_done_now = cpu_busy && (cycle_no == rd_done_cycle);
    f_win = 0; c_win = 0;
    if (cpu_req_m && freq) begin
      if (video && wait_grants < MAX_STALL) f_win = 1; else c_win = 1;
    end else begin
      c_win = cpu_req_m;
      f_win = freq;
    end
    is_wr = c_win && wr;
    exp_v = (fq.size() > 0) && (fq[0].due == cycle_no);

    checkOutput("fetch_gnt", 32'(fetch_gnt), 32'(f_win));
    checkOutput("ram_wren", 32'(ram_wren), 32'(is_wr));
    checkOutput("waitreq", 32'(avl_waitreq), 32'(!(is_wr || rd_done_now)));
    checkOutput("fetch_valid", 32'(fetch_valid), 32'(exp_v));
    if (f_win) checkOutput("ram_addr_f", 32'(ram_addr), 32'(faddr));
    if (c_win) checkOutput("ram_addr_c", 32'(ram_addr), 32'(addr));
    if (is_wr) begin
      checkOutput("ram_wdata", ram_wdata, wdata);
      checkOutput("ram_byteen", 32'(ram_byteen), 32'(be));
    end
    if (exp_v) begin
      checkOutput("fetch_data", fetch_data, fq[0].data);
      void'(fq.pop_front());
    end
    if (rd_done_now) checkOutput("readdata", avl_readdata, rd_exp);

    if (f_win) fq.push_back('{due: cycle_no + RD_LAT, data: ref_mem[faddr]});
    if (c_win && !wr) begin
      cpu_busy = 1;
      rd_done_cycle = cycle_no + RD_LAT + 1;
      rd_exp = ref_mem[addr];
    end
    if (is_wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[addr][8*b +: 8] = wdata[8*b +: 8];
    end
    wait_grants = (cpu_req_m && f_win) ? wait_grants + 1 : 0;
    if (rd_done_now) cpu_busy = 0;
    cpu_done_now = is_wr || rd_done_now;
    fetch_taken  = f_win;

    @(posedge clk); #1;
    cycle_no++;
    if (cpu_done_now) begin
      cs = 0; rd = 0; wr = 0; cpu_active = 0;
    end
    if (fetch_taken) freq = 0;
  endtask

  task automatic waitCpuDone(input int limit);
    int n;
    n = 0;
    while (cpu_active && n < limit) begin
      stepCycle();
      n++;
    end
    if (cpu_active) checkOutput("cpu_timeout", 32'd1, 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_waitreq"}, 32'(avl_waitreq), 32'd1);
    checkOutput({tag, "_readdata"}, avl_readdata, 32'd0);
    checkOutput({tag, "_fgnt"}, 32'(fetch_gnt), 32'd0);
    checkOutput({tag, "_fvalid"}, 32'(fetch_valid), 32'd0);
    checkOutput({tag, "_fdata"}, fetch_data, 32'd0);
    checkOutput({tag, "_wren"}, 32'(ram_wren), 32'd0);
    checkOutput({tag, "_raddr"}, 32'(ram_addr), 32'd0);
    checkOutput({tag, "_rwdata"}, ram_wdata, 32'd0);
    checkOutput({tag, "_rbe"}, 32'(ram_byteen), 32'd0);
  endtask

  // Random traffic: CPU ops only when idle, fetch requests re-armed at random.
  task automatic applyStimulus();
    int op;
    video = ($urandom_range(0, 4) != 0);
    if (!cpu_active && $urandom_range(0, 2) == 0) begin
      op = $urandom_range(0, 4);
      startCpu(op != 2 && op != 3, op >= 2, 11'($urandom_range(0, 63)),
               4'($urandom_range(0, 15)), $urandom);
    end
    if (!freq && $urandom_range(0, 1) == 1) begin
      freq  = 1;
      faddr = 11'($urandom_range(0, 63));
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i]     = 32'(i);
      ref_mem[i] = 32'(i);
    end
    rst_n = 0; cs = 0; rd = 0; wr = 0; addr = '0; be = '0; wdata = '0;
    video = 0; freq = 0; faddr = '0;
    #3;
    checkResetOutputs("rst");
    @(posedge clk); #1;
    rst_n = 1;

    // Write then read back address 0x005
    startCpu(0, 1, 11'h005, 4'hF, 32'hDEADBEEF);
    waitCpuDone(20);
    startCpu(1, 0, 11'h005, 4'hF, 32'h0);
    waitCpuDone(20);

    // CPU read starved by active-video fetches, bounded by MAX_STALL
    video = 1;
    startCpu(1, 0, 11'h005, 4'hF, 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (!freq) begin
        freq  = 1;
        faddr = 11'(8'h30 + i);
      end
      stepCycle();
    end
    freq = 0;
    waitCpuDone(20);

    // Blanking: CPU first, fetch next cycle
    video = 0;
    startCpu(1, 0, 11'h006, 4'hF, 32'h0);
    freq = 1; faddr = 11'h040;
    stepCycle();
    stepCycle();
    waitCpuDone(20);

    // Back-to-back fetches 0x010..0x01F
    video = 1;
    for (int i = 0; i < 16; i++) begin
      freq  = 1;
      faddr = 11'(16 + i);
      stepCycle();
    end
    freq = 0;
    for (int i = 0; i < RD_LAT + 1; i++) stepCycle();

    // Reset while a CPU read and a fetch are in flight
    video = 0;
    startCpu(1, 0, 11'h007, 4'hF, 32'h0);
    stepCycle();
    freq = 1; faddr = 11'h011;
    stepCycle();
    freq = 1; faddr = 11'h012;
    rst_n = 0;
    #2;
    checkResetOutputs("midrst");
    cs = 0; rd = 0; wr = 0; freq = 0;
    cpu_active = 0; cpu_busy = 0; wait_grants = 0;
    fq.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < RD_LAT + 2; i++) stepCycle();
    startCpu(1, 0, 11'h005, 4'hF, 32'h0);
    waitCpuDone(20);

    // Read and write together: write wins with low-half byte enables
    startCpu(1, 1, 11'h020, 4'h3, 32'hAAAA5555);
    waitCpuDone(20);
    for (int i = 0; i < RD_LAT + 2; i++) stepCycle();
    startCpu(1, 0, 11'h020, 4'hF, 32'h0);
    waitCpuDone(20);
    checkOutput("rw_merge", avl_readdata, 32'h00005555);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      applyStimulus();
      stepCycle();
    end
    freq = 0;
    waitCpuDone(40);
    for (int i = 0; i < RD_LAT + 2; i++) stepCycle();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
